// File: rtl/riscv_mem_arb.sv
// Instruction/data memory arbiter with starvation guard.
// Data side wins ties; a fetch denied STARVE_LIMIT cycles in a row gets
// priority next. Grants and memory request outputs are combinational. Read
// responses are tagged one cycle later. Read data is passed straight through.
module riscv_mem_arb #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // Instruction side
  input  logic          i_imem_req,
  input  logic [AW-1:0] i_imem_addr,
  output logic          o_imem_gnt,
  output logic          o_imem_rvalid,
  output logic [DW-1:0] o_imem_rdata,
  // Data side
  input  logic          i_dmem_req,
  input  logic          i_dmem_wr_en,
  input  logic [3:0]    i_dmem_byte_sel,
  input  logic [AW-1:0] i_dmem_addr,
  input  logic [DW-1:0] i_dmem_wdata,
  output logic          o_dmem_gnt,
  output logic          o_dmem_rvalid,
  output logic [DW-1:0] o_dmem_rdata,
  // Memory side
  input  logic          i_mem_ready,
  output logic          o_mem_req,
  output logic          o_mem_wr_en,
  output logic [3:0]    o_mem_byte_sel,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam logic [3:0] LP_LIMIT = STARVE_LIMIT[3:0];

  logic [3:0] r_starve_cnt;
  logic       r_rsp_i;
  logic       r_rsp_d;
  logic       w_starve;
  logic       w_imem_gnt;
  logic       w_dmem_gnt;

  assign w_starve   = (r_starve_cnt == LP_LIMIT);
  assign w_imem_gnt = i_mem_ready & i_imem_req & (~i_dmem_req | w_starve);
  assign w_dmem_gnt = i_mem_ready & i_dmem_req & ~w_imem_gnt;

  assign o_imem_gnt = w_imem_gnt;
  assign o_dmem_gnt = w_dmem_gnt;

  // Steer the granted requester onto the memory port; idle drives all zeros.
  always_comb begin
    o_mem_req      = w_imem_gnt | w_dmem_gnt;
    o_mem_wr_en    = 1'b0;
    o_mem_byte_sel = 4'b0000;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    if (w_imem_gnt) begin
      o_mem_byte_sel = 4'b1111;
      o_mem_addr     = i_imem_addr;
    end else if (w_dmem_gnt) begin
      o_mem_wr_en    = i_dmem_wr_en;
      o_mem_byte_sel = i_dmem_byte_sel;
      o_mem_addr     = i_dmem_addr;
      o_mem_wdata    = i_dmem_wdata;
    end
  end

  // Count consecutive denied fetch cycles (including ready=0), saturating.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= 4'd0;
    end else if (i_imem_req && !w_imem_gnt) begin
      if (!w_starve) r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  // Tag which side owns the read data returning next cycle; stores get no tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_i <= 1'b0;
      r_rsp_d <= 1'b0;
    end else begin
      r_rsp_i <= w_imem_gnt;
      r_rsp_d <= w_dmem_gnt & ~i_dmem_wr_en;
    end
  end

  assign o_imem_rvalid = r_rsp_i;
  assign o_dmem_rvalid = r_rsp_d;
  assign o_imem_rdata  = i_mem_rdata;
  assign o_dmem_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Self-checking bench for riscv_mem_arb: directed scenarios then a random
// run with held requests, checked against a streak-counting reference model.
module tb_riscv_mem_arb;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_imem_req;
  logic [AW-1:0] i_imem_addr;
  logic          o_imem_gnt, o_imem_rvalid;
  logic [DW-1:0] o_imem_rdata;
  logic          i_dmem_req, i_dmem_wr_en;
  logic [3:0]    i_dmem_byte_sel;
  logic [AW-1:0] i_dmem_addr;
  logic [DW-1:0] i_dmem_wdata;
  logic          o_dmem_gnt, o_dmem_rvalid;
  logic [DW-1:0] o_dmem_rdata;
  logic          i_mem_ready, o_mem_req, o_mem_wr_en;
  logic [3:0]    o_mem_byte_sel;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata, i_mem_rdata;

  riscv_mem_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_imem_req(i_imem_req), .i_imem_addr(i_imem_addr), .o_imem_gnt(o_imem_gnt),
    .o_imem_rvalid(o_imem_rvalid), .o_imem_rdata(o_imem_rdata),
    .i_dmem_req(i_dmem_req), .i_dmem_wr_en(i_dmem_wr_en), .i_dmem_byte_sel(i_dmem_byte_sel),
    .i_dmem_addr(i_dmem_addr), .i_dmem_wdata(i_dmem_wdata), .o_dmem_gnt(o_dmem_gnt),
    .o_dmem_rvalid(o_dmem_rvalid), .o_dmem_rdata(o_dmem_rdata),
    .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req), .o_mem_wr_en(o_mem_wr_en),
    .o_mem_byte_sel(o_mem_byte_sel), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: length of the current run of denied fetch cycles and
  // which side expects read data this cycle.
  int unsigned m_streak = 0;
  bit          m_rv_i = 1'b0, m_rv_d = 1'b0;
  bit          m_gi, m_gd;
  logic        g_i, g_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned exp_cnt();
    return (m_streak > STARVE_LIMIT) ? STARVE_LIMIT : m_streak;
  endfunction

  // Apply inputs just after a rising edge, check mid-cycle, advance the model.
  task automatic cyc(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                     input logic [3:0] bs, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                     input bit rdy, input logic [DW-1:0] mrd);
    bit prio_i;
    i_imem_req = ir; i_imem_addr = ia; i_dmem_req = dr; i_dmem_wr_en = dw;
    i_dmem_byte_sel = bs; i_dmem_addr = da; i_dmem_wdata = wd;
    i_mem_ready = rdy; i_mem_rdata = mrd;
    #3;
    prio_i = (m_streak >= STARVE_LIMIT);
    m_gi = rdy & ir & (~dr | prio_i);
    m_gd = rdy & dr & ~m_gi;
    g_i = o_imem_gnt; g_d = o_dmem_gnt;
    chk("imem_gnt", 64'(o_imem_gnt), 64'(m_gi));
    chk("dmem_gnt", 64'(o_dmem_gnt), 64'(m_gd));
    chk("mem_req", 64'(o_mem_req), 64'(m_gi | m_gd));
    chk("mem_wr_en", 64'(o_mem_wr_en), 64'(m_gd ? dw : 1'b0));
    chk("mem_byte_sel", 64'(o_mem_byte_sel), 64'(m_gi ? 4'hF : (m_gd ? bs : 4'h0)));
    chk("mem_addr", 64'(o_mem_addr), 64'(m_gi ? ia : (m_gd ? da : '0)));
    chk("mem_wdata", 64'(o_mem_wdata), 64'(m_gd ? wd : '0));
    chk("imem_rvalid", 64'(o_imem_rvalid), 64'(m_rv_i));
    chk("dmem_rvalid", 64'(o_dmem_rvalid), 64'(m_rv_d));
    chk("starve_cnt", 64'(dut.r_starve_cnt), 64'(exp_cnt()));
    if (m_rv_i) chk("imem_rdata", 64'(o_imem_rdata), 64'(mrd));
    if (m_rv_d) chk("dmem_rdata", 64'(o_dmem_rdata), 64'(mrd));
    @(posedge i_clk);
    if (ir && !m_gi) m_streak++;
    else m_streak = 0;
    m_rv_i = m_gi;
    m_rv_d = m_gd & ~dw;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1, '0);
  endtask

  bit            p_i, p_d, r_dw;
  logic [AW-1:0] r_ia, r_da;
  logic [3:0]    r_bs;
  logic [DW-1:0] r_wd;

  initial begin
    i_rst = 1'b1;
    i_imem_req = 0; i_imem_addr = '0; i_dmem_req = 0; i_dmem_wr_en = 0;
    i_dmem_byte_sel = '0; i_dmem_addr = '0; i_dmem_wdata = '0;
    i_mem_ready = 0; i_mem_rdata = '0;
    @(posedge i_clk); @(posedge i_clk); #3;
    chk("rst_imem_rvalid", 64'(o_imem_rvalid), 64'(0));
    chk("rst_dmem_rvalid", 64'(o_dmem_rvalid), 64'(0));
    chk("rst_starve_cnt", 64'(dut.r_starve_cnt), 64'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle();

    // Fetch-only read, data returns next cycle.
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1, '0);
    chk("s1_gnt", 64'(g_i), 64'(1));
    cyc(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 32'hDEADBEEF);
    chk("s1_rdata", 64'(o_imem_rdata), 64'(32'hDEADBEEF));

    // Simultaneous fetch and load: data wins, streak starts.
    cyc(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h300, '0, 1'b1, '0);
    chk("s2_dgnt", 64'(g_d), 64'(1));
    chk("s2_cnt", 64'(dut.r_starve_cnt), 64'(1));
    idle();

    // Continuous loads plus a fetch: fetch wins only on cycle 4.
    for (int k = 0; k < 6; k++) begin
      cyc(k < 5, 32'h400, 1'b1, 1'b0, 4'hF, 32'h500 + 32'(k), '0, 1'b1, '0);
      chk("s3_ignt", 64'(g_i), 64'(k == 4));
      chk("s3_dgnt", 64'(g_d), 64'(k != 4));
    end
    idle();

    // Store: pass-through fields, no load response afterwards.
    cyc(1'b0, '0, 1'b1, 1'b1, 4'b0011, 32'h600, 32'h1234, 1'b1, '0);
    idle();
    chk("s4_no_rvalid", 64'(o_dmem_rvalid), 64'(0));

    // Memory stalled six cycles with both requests held, then fetch first.
    for (int k = 0; k < 6; k++)
      cyc(1'b1, 32'h700, 1'b1, 1'b0, 4'h1, 32'h800, '0, 1'b0, '0);
    cyc(1'b1, 32'h700, 1'b1, 1'b0, 4'h1, 32'h800, '0, 1'b1, '0);
    chk("s5_ignt", 64'(g_i), 64'(1));
    cyc(1'b0, '0, 1'b1, 1'b0, 4'h1, 32'h800, '0, 1'b1, 32'h55);
    idle();

    // Reset the cycle after a fetch grant: its response must vanish.
    cyc(1'b1, 32'h900, 1'b1, 1'b0, 4'hF, 32'hA00, '0, 1'b1, '0);
    cyc(1'b1, 32'h900, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1, '0);
    i_rst = 1'b1; i_imem_req = 1'b0;
    #3;
    chk("s6_rvalid", 64'(o_imem_rvalid), 64'(0));
    chk("s6_cnt", 64'(dut.r_starve_cnt), 64'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    m_streak = 0; m_rv_i = 0; m_rv_d = 0;
    idle();

    // Random traffic; requests are held until the model says granted.
    p_i = 0; p_d = 0;
    for (int n = 0; n < 400; n++) begin
      if (!p_i && $urandom_range(0, 1) == 1) begin
        p_i = 1; r_ia = $urandom;
      end
      if (!p_d && $urandom_range(0, 2) != 0) begin
        p_d = 1; r_dw = 1'($urandom_range(0, 1)); r_da = $urandom; r_wd = $urandom;
        case ($urandom_range(0, 2))
          0: r_bs = 4'b0001;
          1: r_bs = 4'b0011;
          default: r_bs = 4'b1111;
        endcase
      end
      cyc(p_i, p_i ? r_ia : '0, p_d, p_d & r_dw, p_d ? r_bs : 4'h0, p_d ? r_da : '0,
          p_d ? r_wd : '0, $urandom_range(0, 3) != 0, $urandom);
      if (m_gi) p_i = 0;
      if (m_gd) p_d = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_mem_arb.md
RISCV_MEM_ARB -- requirements
Module: riscv_mem_arb

Interface
REQ-001 Parameter: AW, 32, address width.
REQ-002 Parameter: DW, 32, data width.
REQ-003 Parameter: STARVE_LIMIT, 4, consecutive denied instruction-request cycles before instruction side takes priority; legal range 1..15.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
REQ-005 Instruction-side ports SHALL be:
- i_imem_req  in  1  fetch request, held until granted.
- i_imem_addr  in  AW  fetch address.
- o_imem_gnt  out  1  fetch accepted this cycle.
- o_imem_rvalid  out  1  fetch data valid.
- o_imem_rdata  out  DW  fetch data.
REQ-006 Data-side ports SHALL be:
- i_dmem_req  in  1  load/store request, held until granted.
- i_dmem_wr_en  in  1  1=store, 0=load.
- i_dmem_byte_sel  in  4  byte enables (0001/0011/1111).
- i_dmem_addr  in  AW  data address.
- i_dmem_wdata  in  DW  store data.
- o_dmem_gnt  out  1  access accepted this cycle.
- o_dmem_rvalid  out  1  load data valid.
- o_dmem_rdata  out  DW  load data.
REQ-007 Memory-side ports SHALL be:
- i_mem_ready  in  1  memory can accept a request this cycle.
- o_mem_req  out  1  request issued.
- o_mem_wr_en  out  1  write strobe.
- o_mem_byte_sel  out  4  byte enables.
- o_mem_addr  out  AW  address.
- o_mem_wdata  out  DW  write data.
- i_mem_rdata  in  DW  read data, valid the cycle after an accepted read.

Function
REQ-008 The grant signals SHALL be combinational in the request cycle:
- starve = (starve_cnt == STARVE_LIMIT).
- o_imem_gnt = i_mem_ready & i_imem_req & (~i_dmem_req | starve).
- o_dmem_gnt = i_mem_ready & i_dmem_req & ~o_imem_gnt.
REQ-009 At most one grant SHALL be high in any cycle, and no grant SHALL be issued while i_mem_ready=0.
REQ-010 The memory request outputs SHALL be driven as follows:
- o_mem_req = o_imem_gnt | o_dmem_gnt.
- On an instruction grant: addr = i_imem_addr, wr_en = 0, byte_sel = 1111, wdata = 0.
- On a data grant: the i_dmem_* fields pass through.
- With no grant: all memory outputs are 0.
REQ-011 The response tag SHALL be two registered bits:
- rsp_i is set by an instruction grant.
- rsp_d is set by a data grant with i_dmem_wr_en=0.
- Both are cleared otherwise, each cycle.
REQ-012 The response outputs SHALL be:
- o_imem_rvalid = rsp_i and o_dmem_rvalid = rsp_d, exactly one cycle after the grant.
- Read latency is 1 cycle.
- Stores produce no rvalid.
REQ-013 The rdata outputs SHALL follow i_mem_rdata unconditionally and are meaningful only while the matching rvalid is high.
REQ-014 starve_cnt SHALL be a 4-bit counter, evaluated each cycle:
- If i_imem_req=1 and o_imem_gnt=0, it increments, saturating at STARVE_LIMIT.
- Otherwise it clears to 0.
REQ-015 Effective arbitration states:
- DATA_PRIO (starve=0) and INST_PRIO (starve=1).
- DATA_PRIO -> INST_PRIO after STARVE_LIMIT consecutive denied fetch cycles.
- INST_PRIO -> DATA_PRIO on the cycle after the fetch grant.
REQ-016 Denials caused by i_mem_ready=0 SHALL count toward starvation.
REQ-017 Back-to-back grants SHALL be supported every cycle, and a new grant in the cycle where rvalid is high SHALL be legal.

Reset
REQ-018 While i_rst=1 the following SHALL be held at 0, asynchronously: starve_cnt, rsp_i, rsp_d, o_imem_rvalid, o_dmem_rvalid.
REQ-019 Combinational outputs SHALL follow REQ-008/REQ-010 from the input values during reset; memory-side validity is the memory's responsibility.
REQ-020 Reset asserted one cycle after a read grant SHALL suppress that read's rvalid.

Verification
REQ-021 Bench SHALL cover the following scenarios:
- Imem-only read, addr=0x100, i_mem_rdata=0xDEADBEEF next cycle -> o_imem_gnt=1, o_mem_wr_en=0, o_mem_byte_sel=1111; o_imem_rvalid=1 with 0xDEADBEEF one cycle later.
- Simultaneous imem and dmem load, starve_cnt=0 -> o_dmem_gnt=1, o_imem_gnt=0, o_mem_addr=dmem addr; starve_cnt=1 next cycle.
- Continuous dmem requests plus imem request, STARVE_LIMIT=4 -> dmem granted cycles 0-3, imem granted cycle 4, dmem granted cycle 5.
- Dmem store, byte_sel=0011, wdata=0x1234 -> o_mem_wr_en=1, byte_sel=0011, wdata=0x1234; no o_dmem_rvalid afterwards.
- i_mem_ready=0 for 6 cycles with both requests held -> no grants; on ready=1, imem granted first.
- Reset pulse the cycle after an imem read grant -> o_imem_rvalid stays 0 and starve_cnt=0.
